branch_hazard_controller: RTL and testbench
===========================================

// Module: branch_hazard_controller
// PURPOSE
//  Sequences ID-stage stalls, flushes and branch-operand forwarding for the 5-stage MIPS pipeline.
//  Branches (beq/bne) resolve in ID, so producers still in EX or MEM must stall ID or be forwarded.
//  Drives PC/IF-ID write enables, ID/EX bubble insert, IF/ID flush and ID comparator mux selects.
//  Keeps a saturating hazard-stall counter.
// PARAMETERS
//  BEQ_OP  6'b000100  beq opcode
//  BNE_OP  6'b000101  bne opcode
//  SW_OP   6'b101011  sw opcode; rt is a source
//  CNT_W   16         stall_cycles width
// PORTS
//  clk            in   1      clock, rising edge
//  rst_n          in   1      synchronous reset, active-low
//  id_instr       in   32     IF/ID instruction: [31:26] op, [25:21] rs, [20:16] rt
//  ex_dest        in   5      ID/EX destination register
//  ex_reg_write   in   1      ID/EX writes the register file
//  ex_mem_read    in   1      ID/EX is a load
//  mem_dest       in   5      EX/MEM destination register
//  mem_reg_write  in   1      EX/MEM writes the register file
//  mem_mem_read   in   1      EX/MEM is a load
//  branch_taken   in   1      ID comparator result; valid only when no stall is issued
//  ext_hold       in   1      memory wait: freeze the whole pipe
//  pc_write       out  1      PC load enable
//  ifid_write     out  1      IF/ID load enable
//  idex_bubble    out  1      zero ID/EX control (insert nop)
//  ifid_flush     out  1      clear IF/ID on next edge
//  fwd_a_sel      out  2      rs comparator mux: 00 regfile, 10 EX/MEM ALU result, 11 MEM/WB data
//  fwd_b_sel      out  2      rt comparator mux, same encoding
//  ctrl_state     out  1      0 RUN, 1 STALL
//  stall_cycles   out  CNT_W  hazard-stall cycles, saturating
// BEHAVIOUR
//  Matching: a producer matches src when dest==src, reg_write=1 and dest!=0. Register 0 never matches.
//  Sources:
//   - Branch: rs and rt.
//   - Opcode 0 or SW_OP: rs and rt.
//   - Otherwise: rs only.
//  Required stalls N, evaluated in RUN only:
//   - Branch, EX producer is a load: N=2.
//   - Branch, EX producer is ALU: N=1.
//   - Branch, MEM producer is a load: N=1.
//   - Non-branch, EX producer is a load: N=1.
//   - Otherwise N=0. Take the maximum over both sources.
//  Forwarding: only for a branch in RUN with N=0. A MEM ALU match gives 10.
//   MEM/WB data is selected by the datapath on an earlier stall; no MEM match gives 00.
//   Forward selects are 00 in all other cases.
//  FSM: 2-bit stall_rem register.
//   - RUN, N>0: stall cycle; stall_rem<=N-1; next state STALL if N==2, else RUN.
//   - RUN, N=0: no stall.
//   - STALL: stall cycle; stall_rem decrements; return to RUN when stall_rem==1 before decrement.
//     No re-evaluation in STALL.
//   - Result: N=1 gives 1 stall cycle, N=2 gives 2 consecutive stall cycles. Re-evaluate on return to RUN.
//  Stall cycle outputs: pc_write=0, ifid_write=0, idex_bubble=1, ifid_flush=0, stall_cycles+1 (hold at max).
//  Non-stall RUN outputs: pc_write=1, ifid_write=1, idex_bubble=0.
//   ifid_flush = branch op & branch_taken.
//  branch_taken is ignored during stall cycles.
//  Priority: reset > ext_hold > STALL > RUN.
//  ext_hold=1:
//   - Outputs: pc_write=0, ifid_write=0, idex_bubble=0, ifid_flush=0, fwd=00.
//   - Held: state, stall_rem and counter.
//  Reset (rst_n=0 at an edge):
//   - state RUN, stall_rem=0, stall_cycles=0.
//   - While rst_n=0, outputs: pc_write=0, ifid_write=0, idex_bubble=1, ifid_flush=0, fwd=00.
//   - Reset mid-STALL abandons the remaining stall count.
//  Outputs are combinational from the state register and current inputs; zero-cycle latency to the hazard.
// TESTING
//  1. lw $2 in EX, beq $2,$3 in ID -> 2 stall cycles (pc_write=0, idex_bubble=1); ctrl_state 0,1,0; stall_cycles=2.
//  2. add $4 in MEM, beq $4,$5 in ID, EX unrelated -> no stall; fwd_a_sel=10, fwd_b_sel=00.
//     branch_taken=1 -> ifid_flush=1 for that cycle.
//  3. lw $6 in EX, add $7,$6,$8 in ID -> 1 stall. Same with $0 as dest -> no stall, fwd=00.
//  4. ext_hold=1 on the first STALL cycle for 3 cycles -> pipe frozen, ctrl_state stays 1.
//     Release -> one more stall cycle, then RUN.
//  5. rst_n=0 during STALL -> next edge RUN, stall_cycles=0; outputs at reset values while low.
//  6. Force stall_cycles to 16'hFFFE, then 3 stalls -> saturates at 16'hFFFF.

Source files
------------

// File: rtl/branch_hazard_controller.sv
// ID-stage hazard sequencer: branch-operand stalls, forwarding selects,
// IF/ID flush on taken branches and a saturating stall-cycle counter.
module branch_hazard_controller #(
    parameter logic [5:0] BEQ_OP = 6'b000100,
    parameter logic [5:0] BNE_OP = 6'b000101,
    parameter logic [5:0] SW_OP  = 6'b101011,
    parameter int         CNT_W  = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [31:0]      i_id_instr,
    input  logic [4:0]       i_ex_dest,
    input  logic             i_ex_reg_write,
    input  logic             i_ex_mem_read,
    input  logic [4:0]       i_mem_dest,
    input  logic             i_mem_reg_write,
    input  logic             i_mem_mem_read,
    input  logic             i_branch_taken,
    input  logic             i_ext_hold,
    output logic             o_pc_write,
    output logic             o_ifid_write,
    output logic             o_idex_bubble,
    output logic             o_ifid_flush,
    output logic [1:0]       o_fwd_a_sel,
    output logic [1:0]       o_fwd_b_sel,
    output logic             o_ctrl_state,
    output logic [CNT_W-1:0] o_stall_cycles
);

    typedef enum logic {
        S_RUN   = 1'b0,
        S_STALL = 1'b1
    } state_t;

    state_t           r_state;
    logic [1:0]       r_stall_rem;
    logic [CNT_W-1:0] r_stall_cycles;

    state_t           w_state_nxt;
    logic [1:0]       w_rem_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;

    logic [5:0] w_op;
    logic [4:0] w_rs;
    logic [4:0] w_rt;
    logic       w_is_branch;
    logic       w_uses_rt;
    logic       w_unused;

    assign w_op     = i_id_instr[31:26];
    assign w_rs     = i_id_instr[25:21];
    assign w_rt     = i_id_instr[20:16];
    assign w_unused = ^i_id_instr[15:0];

    assign w_is_branch = (w_op == BEQ_OP) || (w_op == BNE_OP);
    assign w_uses_rt   = w_is_branch || (w_op == 6'd0) || (w_op == SW_OP);

    // Producer matches; register 0 is never a real dependency
    logic w_ex_rs;
    logic w_ex_rt;
    logic w_mem_rs;
    logic w_mem_rt;

    assign w_ex_rs  = i_ex_reg_write && (i_ex_dest != 5'd0)
                      && (i_ex_dest == w_rs);
    assign w_ex_rt  = i_ex_reg_write && (i_ex_dest != 5'd0)
                      && (i_ex_dest == w_rt) && w_uses_rt;
    assign w_mem_rs = i_mem_reg_write && (i_mem_dest != 5'd0)
                      && (i_mem_dest == w_rs);
    assign w_mem_rt = i_mem_reg_write && (i_mem_dest != 5'd0)
                      && (i_mem_dest == w_rt) && w_uses_rt;

    logic [1:0] w_need_rs;
    logic [1:0] w_need_rt;
    logic [1:0] w_need;

    always_comb begin
        w_need_rs = 2'd0;
        w_need_rt = 2'd0;
        if (w_is_branch) begin
            if (w_ex_rs && i_ex_mem_read) begin
                w_need_rs = 2'd2;
            end else if (w_ex_rs || (w_mem_rs && i_mem_mem_read)) begin
                w_need_rs = 2'd1;
            end
            if (w_ex_rt && i_ex_mem_read) begin
                w_need_rt = 2'd2;
            end else if (w_ex_rt || (w_mem_rt && i_mem_mem_read)) begin
                w_need_rt = 2'd1;
            end
        end else begin
            if (w_ex_rs && i_ex_mem_read) begin
                w_need_rs = 2'd1;
            end
            if (w_ex_rt && i_ex_mem_read) begin
                w_need_rt = 2'd1;
            end
        end
        w_need = (w_need_rs > w_need_rt) ? w_need_rs : w_need_rt;
    end

    logic w_stall;
    logic w_cnt_max;

    assign w_cnt_max = (r_stall_cycles == {CNT_W{1'b1}});

    always_comb begin
        w_state_nxt   = r_state;
        w_rem_nxt     = r_stall_rem;
        w_cnt_nxt     = r_stall_cycles;
        w_stall       = 1'b0;
        o_pc_write    = 1'b0;
        o_ifid_write  = 1'b0;
        o_idex_bubble = 1'b0;
        o_ifid_flush  = 1'b0;
        o_fwd_a_sel   = 2'b00;
        o_fwd_b_sel   = 2'b00;

        if (!i_rst_n) begin
            o_idex_bubble = 1'b1;
            w_state_nxt   = S_RUN;
            w_rem_nxt     = 2'd0;
            w_cnt_nxt     = '0;
        end else if (i_ext_hold) begin
            w_state_nxt = r_state;
        end else if (r_state == S_STALL) begin
            // Remaining cycles of a stall decided in RUN; no re-evaluation
            w_stall = 1'b1;
            if (r_stall_rem != 2'd0) begin
                w_rem_nxt = r_stall_rem - 2'd1;
            end
            if (r_stall_rem <= 2'd1) begin
                w_state_nxt = S_RUN;
            end
        end else if (w_need != 2'd0) begin
            w_stall     = 1'b1;
            w_rem_nxt   = w_need - 2'd1;
            w_state_nxt = (w_need == 2'd2) ? S_STALL : S_RUN;
        end else begin
            o_pc_write   = 1'b1;
            o_ifid_write = 1'b1;
            o_ifid_flush = w_is_branch && i_branch_taken;
            if (w_is_branch) begin
                o_fwd_a_sel = (w_mem_rs && !i_mem_mem_read) ? 2'b10 : 2'b00;
                o_fwd_b_sel = (w_mem_rt && !i_mem_mem_read) ? 2'b10 : 2'b00;
            end
        end

        if (w_stall) begin
            o_idex_bubble = 1'b1;
            if (!w_cnt_max) begin
                w_cnt_nxt = r_stall_cycles + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state        <= S_RUN;
            r_stall_rem    <= 2'd0;
            r_stall_cycles <= '0;
        end else begin
            r_state        <= w_state_nxt;
            r_stall_rem    <= w_rem_nxt;
            r_stall_cycles <= w_cnt_nxt;
        end
    end

    assign o_ctrl_state   = r_state;
    assign o_stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_branch_hazard_controller.sv
// Scoreboard bench: directed hazard scenarios then random traffic against
// a pending-stall reference model; a narrow-counter copy covers saturation.
module tb_branch_hazard_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b0;
    logic [31:0] instr = 32'd0;
    logic [4:0]  exd   = 5'd0;
    logic        exw   = 1'b0;
    logic        exr   = 1'b0;
    logic [4:0]  memd  = 5'd0;
    logic        memw  = 1'b0;
    logic        memr  = 1'b0;
    logic        taken = 1'b0;
    logic        hold  = 1'b0;

    logic        pc_w, ifid_w, bub, flush, ctrl;
    logic [1:0]  fa, fb;
    logic [15:0] cnt;

    logic        n_pc_w, n_ifid_w, n_bub, n_flush, n_ctrl;
    logic [1:0]  n_fa, n_fb;
    logic [2:0]  n_cnt;

    branch_hazard_controller dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_id_instr(instr),
        .i_ex_dest(exd), .i_ex_reg_write(exw), .i_ex_mem_read(exr),
        .i_mem_dest(memd), .i_mem_reg_write(memw), .i_mem_mem_read(memr),
        .i_branch_taken(taken), .i_ext_hold(hold),
        .o_pc_write(pc_w), .o_ifid_write(ifid_w), .o_idex_bubble(bub),
        .o_ifid_flush(flush), .o_fwd_a_sel(fa), .o_fwd_b_sel(fb),
        .o_ctrl_state(ctrl), .o_stall_cycles(cnt)
    );

    branch_hazard_controller #(.CNT_W(3)) dut_narrow (
        .i_clk(clk), .i_rst_n(rst_n), .i_id_instr(instr),
        .i_ex_dest(exd), .i_ex_reg_write(exw), .i_ex_mem_read(exr),
        .i_mem_dest(memd), .i_mem_reg_write(memw), .i_mem_mem_read(memr),
        .i_branch_taken(taken), .i_ext_hold(hold),
        .o_pc_write(n_pc_w), .o_ifid_write(n_ifid_w), .o_idex_bubble(n_bub),
        .o_ifid_flush(n_flush), .o_fwd_a_sel(n_fa), .o_fwd_b_sel(n_fb),
        .o_ctrl_state(n_ctrl), .o_stall_cycles(n_cnt)
    );

    typedef struct {
        logic [24:0] v;
        logic [2:0]  c3;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: stall cycles still owed and saturating counters
    int pend  = 0;
    int cnt16 = 0;
    int cnt3  = 0;

    localparam logic [5:0] OP_BEQ = 6'd4;
    localparam logic [5:0] OP_BNE = 6'd5;
    localparam logic [5:0] OP_SW  = 6'd43;
    localparam logic [5:0] OP_LW  = 6'd35;
    localparam logic [5:0] OP_ADDI = 6'd8;

    function automatic bit hit(input logic [4:0] d, input logic w,
                               input logic [4:0] s);
        return w && (d != 5'd0) && (d == s);
    endfunction

    function automatic int src_need(input bit br, input logic [4:0] s);
        bit eh = hit(exd, exw, s);
        bit mh = hit(memd, memw, s);
        if (br) begin
            if (eh && exr) return 2;
            if (eh) return 1;
            if (mh && memr) return 1;
            return 0;
        end
        return (eh && exr) ? 1 : 0;
    endfunction

    task automatic step(input logic r, input logic h, input logic [5:0] op,
                        input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] ed, input logic ew, input logic er,
                        input logic [4:0] md, input logic mw, input logic mr,
                        input logic tk);
        exp_t e;
        logic p, iw, b, f, st;
        logic [1:0] ea, eb;
        bit br, use_rt;
        int n;
        @(posedge clk);
        #1;
        rst_n = r; hold = h;
        instr = {op, rs, rt, 16'($urandom)};
        exd = ed; exw = ew; exr = er;
        memd = md; memw = mw; memr = mr;
        taken = tk;
        cyc++;

        p = 0; iw = 0; b = 0; f = 0; ea = 2'b00; eb = 2'b00; st = 0;
        br = (op == OP_BEQ) || (op == OP_BNE);
        use_rt = br || (op == 6'd0) || (op == OP_SW);
        e.cyc = cyc;
        e.c3  = 3'(cnt3);
        e.v   = 25'd0;
        if (!r) begin
            b = 1;
        end else if (!h) begin
            if (pend > 0) begin
                st = 1;
                pend--;
            end else begin
                n = src_need(br, rs);
                if (use_rt && src_need(br, rt) > n) n = src_need(br, rt);
                if (n > 0) begin
                    st = 1;
                    pend = n - 1;
                end else begin
                    p = 1; iw = 1;
                    f = br && tk;
                    if (br && hit(md, mw, rs) && !mr) ea = 2'b10;
                    if (br && hit(md, mw, rt) && !mr) eb = 2'b10;
                end
            end
            if (st) b = 1;
        end
        e.v = {p, iw, b, f, ea, eb, 1'((e.c3 == 3'd0 && 0) || 0), 16'(cnt16)};
        q.push_back(e);

        // Model state advances for the coming edge
        if (!r) begin
            pend = 0; cnt16 = 0; cnt3 = 0;
        end else if (st) begin
            if (cnt16 < 65535) cnt16++;
            if (cnt3 < 7) cnt3++;
        end
    endtask

    // ctrl_state expectation: STALL exactly while a stall is still owed
    logic ctrl_exp_q[$];
    task automatic note_ctrl();
        ctrl_exp_q.push_back(pend > 0);
    endtask

    task automatic run(input logic r, input logic h, input logic [5:0] op,
                       input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] ed, input logic ew, input logic er,
                       input logic [4:0] md, input logic mw, input logic mr,
                       input logic tk);
        note_ctrl();
        step(r, h, op, rs, rt, ed, ew, er, md, mw, mr, tk);
    endtask

    always @(negedge clk) begin
        exp_t e;
        logic [24:0] act;
        logic [24:0] req;
        if (q.size() > 0 && ctrl_exp_q.size() > 0) begin
            e = q.pop_front();
            req = e.v;
            req[16] = ctrl_exp_q.pop_front();
            act = {pc_w, ifid_w, bub, flush, fa, fb, ctrl, cnt};
            checks++;
            if (act !== req) begin
                errors++;
                $display("FAIL outputs cyc=%0d got=%h required=%h",
                         e.cyc, act, req);
            end
            checks++;
            if (n_cnt !== e.c3) begin
                errors++;
                $display("FAIL narrow_cnt cyc=%0d got=%0d required=%0d",
                         e.cyc, n_cnt, e.c3);
            end
        end
    end

    logic [5:0] ops [6];

    initial begin
        ops[0] = 6'd0; ops[1] = OP_BEQ; ops[2] = OP_BNE;
        ops[3] = OP_SW; ops[4] = OP_LW; ops[5] = OP_ADDI;

        run(0, 0, 6'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        run(0, 0, 6'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // lw $2 in EX, beq $2,$3: two stalls then run
        run(1, 0, OP_BEQ, 2, 3, 2, 1, 1, 0, 0, 0, 0);
        run(1, 0, OP_BEQ, 2, 3, 0, 0, 0, 2, 1, 1, 0);
        run(1, 0, OP_BEQ, 2, 3, 0, 0, 0, 0, 0, 0, 1);

        // add $4 in MEM, beq $4,$5: forward from EX/MEM, taken flush
        run(1, 0, OP_BEQ, 4, 5, 9, 1, 0, 4, 1, 0, 1);
        run(1, 0, OP_BNE, 7, 4, 9, 1, 0, 4, 1, 0, 0);

        // lw $6 in EX, add uses $6: one stall; $0 dest never stalls
        run(1, 0, 6'd0, 6, 8, 6, 1, 1, 0, 0, 0, 0);
        run(1, 0, 6'd0, 6, 8, 0, 0, 0, 6, 1, 1, 0);
        run(1, 0, 6'd0, 0, 8, 0, 1, 1, 0, 0, 0, 0);
        run(1, 0, OP_BEQ, 0, 0, 0, 1, 1, 0, 1, 1, 1);

        // ext_hold on the first STALL cycle
        run(1, 0, OP_BEQ, 2, 3, 2, 1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++)
            run(1, 1, OP_BEQ, 2, 3, 0, 0, 0, 2, 1, 1, 1);
        run(1, 0, OP_BEQ, 2, 3, 0, 0, 0, 2, 1, 1, 1);
        run(1, 0, OP_BEQ, 2, 3, 0, 0, 0, 0, 0, 0, 0);

        // reset during STALL abandons the stall
        run(1, 0, OP_BEQ, 2, 3, 2, 1, 1, 0, 0, 0, 0);
        run(0, 0, OP_BEQ, 2, 3, 0, 0, 0, 2, 1, 1, 0);
        run(1, 0, OP_BEQ, 2, 3, 0, 0, 0, 2, 1, 1, 0);
        run(1, 0, 6'd0, 1, 1, 0, 0, 0, 0, 0, 0, 0);

        // random traffic; many stalls saturate the 3-bit counter
        for (int i = 0; i < 2000; i++) begin
            run($urandom_range(0, 39) != 0, $urandom_range(0, 9) == 0,
                ops[$urandom_range(0, 5)],
                5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
                5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
                1'($urandom));
        end

        @(posedge clk);
        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain left=%0d required=0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
